// File: rtl/mul8_rr_scheduler_if.sv
//------------------------------------------------------------------------------
// Module      : mul8_rr_scheduler_if
// Description : Bundle of the requester-side and multiplier-side signals of
//               the round-robin multiplier scheduler.
//               Requester side : req, req_a, req_b -> done, resp_product,
//                                resp_err, busy, gnt_idx
//               Multiplier side: mul_start, mul_a, mul_b <- mul_product,
//                                mul_done
//               slave  modport : the scheduler itself
//               master modport : the environment (requesters + multiplier)
// Revision    : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

interface mul8_rr_scheduler_if #(
  parameter int NUM_REQ = 4
);
  localparam int IDX_W = $clog2(NUM_REQ);

  logic [NUM_REQ-1:0]   req;
  logic [8*NUM_REQ-1:0] req_a;
  logic [8*NUM_REQ-1:0] req_b;
  logic [NUM_REQ-1:0]   done;
  logic [15:0]          resp_product;
  logic                 resp_err;
  logic                 busy;
  logic [IDX_W-1:0]     gnt_idx;
  logic                 mul_start;
  logic [7:0]           mul_a;
  logic [7:0]           mul_b;
  logic [15:0]          mul_product;
  logic                 mul_done;

  modport master (
    output req, req_a, req_b, mul_product, mul_done,
    input  done, resp_product, resp_err, busy, gnt_idx,
           mul_start, mul_a, mul_b
  );

  modport slave (
    input  req, req_a, req_b, mul_product, mul_done,
    output done, resp_product, resp_err, busy, gnt_idx,
           mul_start, mul_a, mul_b
  );
endinterface

`default_nettype wire

// File: rtl/mul8_rr_scheduler.sv
//------------------------------------------------------------------------------
// Module      : mul8_rr_scheduler
// Description : Round-robin scheduler time-sharing one sequential 8x8
//               multiplier among NUM_REQ requesters. Latches the winner's
//               operands, pulses mul_start, returns the product to the winner
//               with a one-hot done pulse. All outputs are registered.
// Ports       : clk, rst_n (async, active low), bus (mul8_rr_scheduler_if
//               slave modport: requester bus + multiplier bus)
// Options     : MUL8_SCHED_TIMEOUT_EN - enables a WAIT watchdog of
//               TIMEOUT_CYC cycles that completes the transaction with
//               resp_err=1 and product 0.
// Revision    : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

module mul8_rr_scheduler #(
  parameter int NUM_REQ     = 4,
  parameter int TIMEOUT_CYC = 64
) (
  input  wire logic           clk,
  input  wire logic           rst_n,
  mul8_rr_scheduler_if.slave  bus
);

  localparam int IDX_W = $clog2(NUM_REQ);

  if (NUM_REQ < 2 || NUM_REQ > 8 || TIMEOUT_CYC < 1) begin : g_bad_params
    $error("mul8_rr_scheduler: NUM_REQ must be 2..8 and TIMEOUT_CYC >= 1");
  end

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  state_t               state_q, state_d;
  logic [IDX_W-1:0]     ptr_q, ptr_d;
  logic [IDX_W-1:0]     gnt_idx_q, gnt_idx_d;
  logic                 mul_start_q, mul_start_d;
  logic [7:0]           mul_a_q, mul_a_d;
  logic [7:0]           mul_b_q, mul_b_d;
  logic [NUM_REQ-1:0]   done_q, done_d;
  logic [15:0]          resp_product_q, resp_product_d;
  logic                 resp_err_q, resp_err_d;
  logic                 busy_q, busy_d;

`ifdef MUL8_SCHED_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);
  logic [CNT_W-1:0]     tmo_cnt_q, tmo_cnt_d;
`endif

  // Circular search starting at ptr: the previous winner sits at ptr-1, so it
  // is the last one considered.
  logic                 win_found;
  logic [IDX_W-1:0]     win_idx;

  always_comb begin
    win_found = 1'b0;
    win_idx   = ptr_q;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (!win_found && bus.req[(int'(ptr_q) + k) % NUM_REQ]) begin
        win_found = 1'b1;
        win_idx   = IDX_W'((int'(ptr_q) + k) % NUM_REQ);
      end
    end
  end

  always_comb begin
    state_d        = state_q;
    ptr_d          = ptr_q;
    gnt_idx_d      = gnt_idx_q;
    mul_start_d    = 1'b0;
    mul_a_d        = mul_a_q;
    mul_b_d        = mul_b_q;
    done_d         = '0;
    resp_product_d = resp_product_q;
    resp_err_d     = resp_err_q;
`ifdef MUL8_SCHED_TIMEOUT_EN
    tmo_cnt_d      = tmo_cnt_q;
`endif

    case (state_q)
      ST_IDLE: begin
        if (win_found) begin
          gnt_idx_d   = win_idx;
          mul_a_d     = bus.req_a[8*int'(win_idx) +: 8];
          mul_b_d     = bus.req_b[8*int'(win_idx) +: 8];
          mul_start_d = 1'b1;
          state_d     = ST_WAIT;
`ifdef MUL8_SCHED_TIMEOUT_EN
          tmo_cnt_d   = '0;
`endif
        end
      end

      ST_WAIT: begin
        // A real completion takes precedence over the watchdog in the same cycle.
        if (bus.mul_done) begin
          resp_product_d = bus.mul_product;
          resp_err_d     = 1'b0;
          done_d         = NUM_REQ'(1) << gnt_idx_q;
          state_d        = ST_RESP;
        end
`ifdef MUL8_SCHED_TIMEOUT_EN
        else if (tmo_cnt_q == CNT_W'(TIMEOUT_CYC - 1)) begin
          resp_product_d = '0;
          resp_err_d     = 1'b1;
          done_d         = NUM_REQ'(1) << gnt_idx_q;
          state_d        = ST_RESP;
        end else begin
          tmo_cnt_d = tmo_cnt_q + 1'b1;
        end
`endif
      end

      ST_RESP: begin
        ptr_d   = (gnt_idx_q == IDX_W'(NUM_REQ - 1)) ? '0 : gnt_idx_q + 1'b1;
        state_d = ST_IDLE;
      end

      default: state_d = ST_IDLE;
    endcase

    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= ST_IDLE;
      ptr_q          <= '0;
      gnt_idx_q      <= '0;
      mul_start_q    <= 1'b0;
      mul_a_q        <= '0;
      mul_b_q        <= '0;
      done_q         <= '0;
      resp_product_q <= '0;
      resp_err_q     <= 1'b0;
      busy_q         <= 1'b0;
`ifdef MUL8_SCHED_TIMEOUT_EN
      tmo_cnt_q      <= '0;
`endif
    end else begin
      state_q        <= state_d;
      ptr_q          <= ptr_d;
      gnt_idx_q      <= gnt_idx_d;
      mul_start_q    <= mul_start_d;
      mul_a_q        <= mul_a_d;
      mul_b_q        <= mul_b_d;
      done_q         <= done_d;
      resp_product_q <= resp_product_d;
      resp_err_q     <= resp_err_d;
      busy_q         <= busy_d;
`ifdef MUL8_SCHED_TIMEOUT_EN
      tmo_cnt_q      <= tmo_cnt_d;
`endif
    end
  end

  assign bus.done         = done_q;
  assign bus.resp_product = resp_product_q;
  assign bus.resp_err     = resp_err_q;
  assign bus.busy         = busy_q;
  assign bus.gnt_idx      = gnt_idx_q;
  assign bus.mul_start    = mul_start_q;
  assign bus.mul_a        = mul_a_q;
  assign bus.mul_b        = mul_b_q;

endmodule

`default_nettype wire

// File: tb/tb_mul8_rr_scheduler.sv
//------------------------------------------------------------------------------
// Module      : tb_mul8_rr_scheduler
// Description : Scoreboard bench for mul8_rr_scheduler. A cycle-level
//               reference model predicts grants, start pulses and responses
//               and queues them; a monitor pops and compares.
// Revision    : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_mul8_rr_scheduler;
  localparam int NUM_REQ     = 4;
  localparam int TIMEOUT_CYC = 8;
  localparam int NEVER       = 32'h3fff_ffff;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  mul8_rr_scheduler_if #(.NUM_REQ(NUM_REQ)) bus ();

  mul8_rr_scheduler #(
    .NUM_REQ    (NUM_REQ),
    .TIMEOUT_CYC(TIMEOUT_CYC)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  typedef struct { int cyc; int idx; logic [7:0] a; logic [7:0] b; } start_t;
  typedef struct { int cyc; int idx; logic [15:0] prod; logic err; } resp_t;
  start_t start_q[$];
  resp_t  resp_q[$];

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // reference model state
  int  m_ptr = 0, m_free = 0, m_busy_lo = 1, m_busy_hi = 0, done_sched = -1;
  logic [7:0] m_a, m_b, stub_a, stub_b;
  bit  stall = 0, rand_mode = 0, stray_en = 0, stale_pulse = 0;
  bit  rq[NUM_REQ], hold[NUM_REQ], granted[NUM_REQ];
  logic [7:0] ra[NUM_REQ], rb[NUM_REQ];

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cycle=%0d actual=%0h expected=%0h", name, cyc, act, exp);
    end
  endtask

  // monitor: compares DUT outputs against the queued expectations
  always @(negedge clk) begin
    start_t s;
    resp_t  r;
    if (rst_n) begin
      chk("busy", 32'(bus.busy), 32'(cyc >= m_busy_lo && cyc <= m_busy_hi));
      if (bus.mul_start) begin
        if (start_q.size() == 0) chk("mul_start_unexpected", 32'(bus.mul_start), 0);
        else begin
          s = start_q.pop_front();
          chk("start_cycle", cyc, s.cyc);
          chk("gnt_idx", 32'(bus.gnt_idx), s.idx);
          chk("mul_a", 32'(bus.mul_a), 32'(s.a));
          chk("mul_b", 32'(bus.mul_b), 32'(s.b));
        end
      end else if (start_q.size() != 0 && start_q[0].cyc <= cyc) begin
        s = start_q.pop_front();
        chk("mul_start_missing", 32'(bus.mul_start), 1);
      end
      if (bus.done != '0) begin
        if (resp_q.size() == 0) chk("done_unexpected", 32'(bus.done), 0);
        else begin
          r = resp_q.pop_front();
          chk("done_cycle", cyc, r.cyc);
          chk("done", 32'(bus.done), 32'(1) << r.idx);
          chk("resp_product", 32'(bus.resp_product), 32'(r.prod));
          chk("resp_err", 32'(bus.resp_err), 32'(r.err));
        end
      end else if (resp_q.size() != 0 && resp_q[0].cyc <= cyc) begin
        r = resp_q.pop_front();
        chk("done_missing", 32'(bus.done), 32'(1) << r.idx);
      end
    end
  end

  task automatic drive_inputs();
    for (int i = 0; i < NUM_REQ; i++) begin
      bus.req[i]           = rq[i];
      bus.req_a[8*i +: 8]  = ra[i];
      bus.req_b[8*i +: 8]  = rb[i];
    end
  endtask

  task automatic check_reset_outputs();
    chk("rst_done", 32'(bus.done), 0);
    chk("rst_resp_product", 32'(bus.resp_product), 0);
    chk("rst_resp_err", 32'(bus.resp_err), 0);
    chk("rst_busy", 32'(bus.busy), 0);
    chk("rst_gnt_idx", 32'(bus.gnt_idx), 0);
    chk("rst_mul_start", 32'(bus.mul_start), 0);
    chk("rst_mul_a", 32'(bus.mul_a), 0);
    chk("rst_mul_b", 32'(bus.mul_b), 0);
  endtask

  // one clock cycle of environment: multiplier stub, requesters, model
  task automatic step();
    int w;
    int lat;
    int d;
    @(negedge clk); #1;
    if (bus.mul_start) begin
      stub_a = bus.mul_a;
      stub_b = bus.mul_b;
    end
    bus.mul_done    = 1'b0;
    bus.mul_product = 16'($urandom);
    if (cyc == done_sched) begin
      bus.mul_done    = 1'b1;
      bus.mul_product = 16'(stub_a) * 16'(stub_b);
      chk("mul_a_hold", 32'(bus.mul_a), 32'(m_a));
      chk("mul_b_hold", 32'(bus.mul_b), 32'(m_b));
    end else if (stale_pulse ||
                 (stray_en && !(cyc >= m_busy_lo && cyc < m_busy_hi) &&
                  $urandom_range(0, 3) == 0)) begin
      bus.mul_done = 1'b1;
      stale_pulse  = 0;
    end

    for (int i = 0; i < NUM_REQ; i++) begin
      if (granted[i]) begin
        granted[i] = 0;
        if (rand_mode) begin
          rq[i] = bit'($urandom_range(0, 1));
          ra[i] = 8'($urandom);
          rb[i] = 8'($urandom);
        end else if (!hold[i]) rq[i] = 0;
      end else if (rand_mode && !rq[i] && $urandom_range(0, 3) == 0) begin
        rq[i] = 1;
        ra[i] = 8'($urandom);
        rb[i] = 8'($urandom);
      end
    end
    drive_inputs();

    // reference model: grant the first requester at or after ptr (circular)
    w = -1;
    if (cyc >= m_free) begin
      for (int k = 0; k < NUM_REQ; k++)
        if (w < 0 && rq[(m_ptr + k) % NUM_REQ]) w = (m_ptr + k) % NUM_REQ;
    end
    if (w >= 0) begin
      m_a = ra[w];
      m_b = rb[w];
      start_q.push_back('{cyc + 1, w, m_a, m_b});
      if (!stall) begin
        lat        = $urandom_range(0, TIMEOUT_CYC - 1);
        done_sched = cyc + 1 + lat;
        d          = done_sched + 1;
        resp_q.push_back('{d, w, 16'(m_a) * 16'(m_b), 1'b0});
      end else begin
        done_sched = -1;
`ifdef MUL8_SCHED_TIMEOUT_EN
        d = cyc + 1 + TIMEOUT_CYC;
        resp_q.push_back('{d, w, 16'h0000, 1'b1});
`else
        d = NEVER;
`endif
      end
      m_busy_lo  = cyc + 1;
      m_busy_hi  = d;
      m_free     = d + 1;
      m_ptr      = (w + 1) % NUM_REQ;
      granted[w] = 1;
    end
  endtask

  task automatic clear_reqs();
    for (int i = 0; i < NUM_REQ; i++) begin
      rq[i] = 0; hold[i] = 0; granted[i] = 0; ra[i] = '0; rb[i] = '0;
    end
  endtask

  task automatic do_reset();
    @(negedge clk); #1;
    rst_n = 1'b0;
    #1;
    check_reset_outputs();
    start_q.delete();
    resp_q.delete();
    m_ptr = 0; m_busy_lo = 1; m_busy_hi = 0; done_sched = -1; stall = 0;
    clear_reqs();
    drive_inputs();
    bus.mul_done = 1'b0;
    @(negedge clk); #1;
    rst_n  = 1'b1;
    m_free = cyc;
  endtask

  task automatic set_req(int i, int a, int b, bit h);
    rq[i] = 1; ra[i] = 8'(a); rb[i] = 8'(b); hold[i] = h;
  endtask

  initial begin
    clear_reqs();
    drive_inputs();
    bus.mul_done    = 1'b0;
    bus.mul_product = '0;
    repeat (3) @(negedge clk);
    #1;
    check_reset_outputs();
    @(negedge clk); #1;
    rst_n  = 1'b1;
    m_free = cyc;

    // single requester, 13*11
    set_req(0, 13, 11, 0);
    repeat (14) step();

    // all four held, distinct operands
    do_reset();
    set_req(0, 3, 5, 1);
    set_req(1, 7, 9, 1);
    set_req(2, 2, 200, 1);
    set_req(3, 16, 16, 1);
    repeat (60) step();

    // max operands on requester 2, then pointer must favour 3 over 1
    do_reset();
    set_req(2, 255, 255, 0);
    repeat (14) step();
    set_req(1, 4, 4, 0);
    set_req(3, 5, 6, 0);
    repeat (30) step();

    // req[0] held, req[1] joins mid-transaction
    do_reset();
    set_req(0, 10, 20, 1);
    repeat (3) step();
    set_req(1, 30, 40, 1);
    repeat (50) step();

    // randomized traffic with stray mul_done pulses
    do_reset();
    rand_mode = 1;
    stray_en  = 1;
    repeat (3000) step();
    rand_mode = 0;
    stray_en  = 0;
    clear_reqs();
    repeat (20) step();

    // stalled multiplier: timeout (if enabled) or stuck busy
    stall = 1;
    set_req(3, 9, 9, 0);
    repeat (TIMEOUT_CYC + 6) step();
    set_req(3, 8, 8, 0);
    repeat (3) step();
    // reset during WAIT, then a stale completion must be ignored
    do_reset();
    stale_pulse = 1;
    repeat (6) step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
